// File: rtl/stream_merge2_pkg.sv
// Shared definitions for the two-to-one stream merger: source tags, lock states
// and the round-robin pick used by the arbiter.
package stream_merge2_pkg;

  // Source tag encoding; matches the DeMux select input.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK_A   = 2'd1,
    LOCK_B   = 2'd2
  } lock_state_t;

  // One-hot grant from a request pair; prio breaks the tie when both request.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
    logic [1:0] g;
    g = 2'b00;
    if (req == 2'b11) begin
      g[prio] = 1'b1;
    end else begin
      g = req;
    end
    return g;
  endfunction

endpackage

// File: rtl/stream_merge2_if.sv
// Handshake bundle of stream_merge2: input channels A and B plus the tagged
// output channel Y. The merger uses the slave view, its environment the master view.
interface stream_merge2_if
  import stream_merge2_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_last;

  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_last;

  logic             y_valid;
  logic             y_ready;
  logic [WIDTH-1:0] y_data;
  logic             y_last;
  logic             y_sel;

  modport slave (
    input  a_valid, a_data, a_last,
    output a_ready,
    input  b_valid, b_data, b_last,
    output b_ready,
    output y_valid, y_data, y_last, y_sel,
    input  y_ready
  );

  modport master (
    output a_valid, a_data, a_last,
    input  a_ready,
    output b_valid, b_data, b_last,
    input  b_ready,
    input  y_valid, y_data, y_last, y_sel,
    output y_ready
  );

endinterface

// File: rtl/stream_merge2_rr_arb2.sv
// Two-way round-robin arbiter holding the priority bit and, when
// STREAM_MERGE2_PACKET_LOCK_EN is defined, the packet lock state.
module rr_arb2
  import stream_merge2_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       load,
  input  logic [1:0] last,
  output logic [1:0] grant
);

  logic prio_reg;

`ifdef STREAM_MERGE2_PACKET_LOCK_EN
  lock_state_t lock_reg;

  // A locked source keeps exclusive access even while idle.
  always_comb begin
    grant = 2'b00;
    if (load && !reset) begin
      case (lock_reg)
        LOCK_A:  grant[SRC_A] = req[SRC_A];
        LOCK_B:  grant[SRC_B] = req[SRC_B];
        default: grant = rr_pick(req, prio_reg);
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio_reg <= SRC_A;
      lock_reg <= UNLOCKED;
    end else if (grant[SRC_A]) begin
      if (last[SRC_A]) begin
        lock_reg <= UNLOCKED;
        prio_reg <= SRC_B;
      end else begin
        lock_reg <= LOCK_A;
      end
    end else if (grant[SRC_B]) begin
      if (last[SRC_B]) begin
        lock_reg <= UNLOCKED;
        prio_reg <= SRC_A;
      end else begin
        lock_reg <= LOCK_B;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    grant = 2'b00;
    if (load && !reset) begin
      grant = rr_pick(req, prio_reg);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio_reg <= SRC_A;
    end else if (grant[SRC_A]) begin
      prio_reg <= SRC_B;
    end else if (grant[SRC_B]) begin
      prio_reg <= SRC_A;
    end
  end
`endif

endmodule

// File: rtl/stream_merge2.sv
// Two-to-one stream merger with a registered, source-tagged output stage.
// Define STREAM_MERGE2_PACKET_LOCK_EN to arbitrate per packet instead of per beat.
module stream_merge2
  import stream_merge2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clock,
  input logic           reset,
  stream_merge2_if.slave bus
);

  logic [1:0]       req;
  logic [1:0]       last;
  logic [1:0]       grant;
  logic             load;

  logic             y_valid_reg;
  logic [WIDTH-1:0] y_data_reg;
  logic             y_last_reg;
  logic             y_sel_reg;

  assign req[SRC_A]  = bus.a_valid;
  assign req[SRC_B]  = bus.b_valid;
  assign last[SRC_A] = bus.a_last;
  assign last[SRC_B] = bus.b_last;

  // Register is free when empty or drained this cycle; y_ready reaches readys combinationally.
  assign load = !y_valid_reg || bus.y_ready;

  rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .load  (load),
    .last  (last),
    .grant (grant)
  );

  assign bus.a_ready = grant[SRC_A];
  assign bus.b_ready = grant[SRC_B];

  always_ff @(posedge clock) begin
    if (reset) begin
      y_valid_reg <= 1'b0;
      y_data_reg  <= '0;
      y_last_reg  <= 1'b0;
      y_sel_reg   <= SRC_A;
    end else if (load) begin
      if (grant[SRC_A]) begin
        y_valid_reg <= 1'b1;
        y_data_reg  <= bus.a_data;
        y_last_reg  <= bus.a_last;
        y_sel_reg   <= SRC_A;
      end else if (grant[SRC_B]) begin
        y_valid_reg <= 1'b1;
        y_data_reg  <= bus.b_data;
        y_last_reg  <= bus.b_last;
        y_sel_reg   <= SRC_B;
      end else begin
        y_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.y_valid = y_valid_reg;
  assign bus.y_data  = y_data_reg;
  assign bus.y_last  = y_last_reg;
  assign bus.y_sel   = y_sel_reg;

endmodule
